// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the IF stage
package fetch_stage_pkg;

  localparam int          NPC_OP_LENGTH    = 3;
  localparam logic [2:0]  NPC_PC4          = 3'd0;
  localparam logic [2:0]  NPC_BRANCH       = 3'd1;
  localparam logic [2:0]  NPC_JUMP         = 3'd2;
  localparam logic [2:0]  NPC_JR           = 3'd3;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_npc_calc.sv
// rtl/fetch_stage_npc_calc.sv - redirect target and redirect decision for the instr in ID
module fetch_stage_npc_calc
  import fetch_stage_pkg::*;
(
  input  logic [NPC_OP_LENGTH-1:0] npc_op,
  input  logic                     valid,
  input  logic [31:0]              pc_plus4,
  input  logic [15:0]              imm16,
  input  logic [25:0]              instr_idx,
  input  logic [31:0]              rs_data,
  output logic [31:0]              target,
  output logic                     redirect
);

  // Unknown opcodes fall through to the default and behave as sequential PC+4.
  always_comb begin
    target   = pc_plus4;
    redirect = 1'b0;
    case (npc_op)
      NPC_BRANCH: begin
        target   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        redirect = valid;
      end
      NPC_JUMP: begin
        target   = {pc_plus4[31:28], instr_idx, 2'b00};
        redirect = valid;
      end
      NPC_JR: begin
        target   = rs_data & ~32'h0000_0003;
        redirect = valid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, next-PC select, 1-entry fetch buffer, IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stallF,
  input  logic [NPC_OP_LENGTH-1:0] npcOp,
  input  logic [15:0]              imm16D,
  input  logic [25:0]              instrIdxD,
  input  logic [31:0]              rsDataD,
  output logic [31:0]              imem_addr,
  output logic                     imem_req,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instrD,
  output logic [31:0]              pcD,
  output logic [31:0]              pcPlus4D,
  output logic                     validD
);

  fetch_state_e state, state_n;
  ifid_t        ifid;
  logic [31:0]  pc_f, pc_plus4_f, buf_word, saved_target, target;
  logic         buf_valid, redirect;

  assign pc_plus4_f = pc_f + 32'd4;
  assign instrD     = ifid.instr;
  assign pcD        = ifid.pc;
  assign pcPlus4D   = ifid.pc_plus4;
  assign validD     = ifid.valid;

  fetch_stage_npc_calc u_npc_calc (
    .npc_op    (npcOp),
    .valid     (ifid.valid),
    .pc_plus4  (ifid.pc_plus4),
    .imm16     (imm16D),
    .instr_idx (instrIdxD),
    .rs_data   (rsDataD),
    .target    (target),
    .redirect  (redirect)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_n;
  end

  // DRAIN waits out an outstanding request whose word belongs to the wrong path.
  always_comb begin
    state_n = state;
    case (state)
      ST_FETCH: if (!stallF && redirect && !buf_valid && !imem_ready) state_n = ST_DRAIN;
      ST_DRAIN: if (imem_ready) state_n = ST_FETCH;
      default:  state_n = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req  = (state == ST_DRAIN) || !buf_valid;
    imem_addr = pc_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f         <= RESET_PC;
      buf_valid    <= 1'b0;
      buf_word     <= NOP_INSTR;
      saved_target <= 32'h0;
      ifid         <= IFID_BUBBLE;
    end else begin
      case (state)
        ST_FETCH: begin
          if (stallF) begin
            if (imem_req && imem_ready) begin
              buf_word  <= imem_rdata;
              buf_valid <= 1'b1;
            end
          end else if (redirect) begin
            ifid <= IFID_BUBBLE;
            if (buf_valid || imem_ready) begin
              pc_f      <= target;
              buf_valid <= 1'b0;
            end else begin
              saved_target <= target;
            end
          end else if (buf_valid) begin
            ifid      <= '{instr: buf_word, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};
            pc_f      <= pc_plus4_f;
            buf_valid <= 1'b0;
          end else if (imem_ready) begin
            ifid <= '{instr: imem_rdata, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};
            pc_f <= pc_plus4_f;
          end else begin
            ifid <= IFID_BUBBLE;
          end
        end
        ST_DRAIN: begin
          if (!stallF)    ifid <= IFID_BUBBLE;
          if (imem_ready) pc_f <= saved_target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stallF, ready_en;
  logic [2:0]  npcOp;
  logic [15:0] imm16D;
  logic [25:0] instrIdxD;
  logic [31:0] rsDataD, imem_addr, imem_rdata, instrD, pcD, pcPlus4D;
  logic        imem_req, imem_ready, validD;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic last_stall = 1'b0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallF(stallF), .npcOp(npcOp), .imm16D(imm16D),
    .instrIdxD(instrIdxD), .rsDataD(rsDataD), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instrD(instrD), .pcD(pcD),
    .pcPlus4D(pcPlus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h2408_0001;
      32'h0000_3204: return 32'h8C09_0004;
      default:       return 32'hAC00_0000 | {16'h0000, a[15:0]};
    endcase
  endfunction

  assign imem_ready = ready_en;
  assign imem_rdata = ready_en ? mem_word(imem_addr) : 32'hDEAD_DEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    sb.push_back('{instr: mem_word(pc), pc: pc});
  endtask

  always @(posedge clk) last_stall <= stallF;

  // A new IF/ID entry appears after every unstalled edge that leaves validD high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && validD && !last_stall) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pc", pcD, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_instr", instrD, e.instr);
        check("sb_pc", pcD, e.pc);
        check("sb_pc4", pcPlus4D, e.pc + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b1; stallF = 1'b0; ready_en = 1'b0; npcOp = NPC_PC4;
    imm16D = 16'h0; instrIdxD = 26'h0; rsDataD = 32'h0;
    #1;
    check("rst_addr", imem_addr, 32'h3000);
    check("rst_valid", {31'h0, validD}, 32'h0);
    check("rst_instr", instrD, 32'h0);
    check("rst_pcd", pcD, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h1);
    step();

    rst = 1'b0; ready_en = 1'b1; expect_fetch(32'h3000);
    step();
    check("first_valid", {31'h0, validD}, 32'h1);
    check("first_addr", imem_addr, 32'h3004);
    expect_fetch(32'h3004);
    step();
    check("seq_pc4d", pcPlus4D, 32'h3008);

    npcOp = NPC_BRANCH; imm16D = 16'hFFFF;
    step();
    npcOp = NPC_PC4;
    check("br_addr", imem_addr, 32'h3004);
    check("br_bubble", {31'h0, validD}, 32'h0);

    expect_fetch(32'h3004);
    step();
    npcOp = NPC_JUMP; instrIdxD = 26'h000_0C40;
    step();
    npcOp = NPC_PC4;
    check("j_addr", imem_addr, 32'h3100);
    check("j_bubble", {31'h0, validD}, 32'h0);

    expect_fetch(32'h3100);
    step();
    npcOp = NPC_JR; rsDataD = 32'h3203;
    step();
    npcOp = NPC_PC4;
    check("jr_addr", imem_addr, 32'h3200);

    expect_fetch(32'h3200);
    step();
    stallF = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_addr", imem_addr, 32'h3204);
      check("stall_pcd", pcD, 32'h3200);
      check("stall_valid", {31'h0, validD}, 32'h1);
    end
    stallF = 1'b0; expect_fetch(32'h3204);
    step();
    check("unstall_addr", imem_addr, 32'h3208);
    check("unstall_instr", instrD, 32'h8C09_0004);
    check("unstall_req", {31'h0, imem_req}, 32'h1);

    ready_en = 1'b0; npcOp = NPC_JUMP; instrIdxD = 26'h000_0D00;
    step();
    npcOp = NPC_PC4;
    check("drain_addr", imem_addr, 32'h3208);
    check("drain_req", {31'h0, imem_req}, 32'h1);
    check("drain_valid", {31'h0, validD}, 32'h0);
    step();
    check("drain_hold_addr", imem_addr, 32'h3208);
    ready_en = 1'b1;
    step();
    check("drain_done_addr", imem_addr, 32'h3400);
    check("drain_done_valid", {31'h0, validD}, 32'h0);

    expect_fetch(32'h3400);
    step();
    npcOp = 3'd5; expect_fetch(32'h3404);
    step();
    npcOp = NPC_PC4;
    check("op5_seq_addr", imem_addr, 32'h3408);

    ready_en = 1'b0; npcOp = NPC_JUMP; instrIdxD = 26'h000_0D00;
    step();
    npcOp = NPC_PC4;
    check("pre_rst_drain_addr", imem_addr, 32'h3408);
    #2 rst = 1'b1;
    #1;
    check("arst_drain_addr", imem_addr, 32'h3000);
    check("arst_drain_valid", {31'h0, validD}, 32'h0);
    check("arst_drain_instr", instrD, 32'h0);
    step();
    rst = 1'b0; ready_en = 1'b1; stallF = 1'b1;
    step();
    check("buf_fill_req", {31'h0, imem_req}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("arst_buf_req", {31'h0, imem_req}, 32'h1);
    check("arst_buf_addr", imem_addr, 32'h3000);
    step();
    rst = 1'b0; stallF = 1'b0; ready_en = 1'b0;
    step();
    check("buf_dropped_valid", {31'h0, validD}, 32'h0);
    ready_en = 1'b1; expect_fetch(32'h3000);
    step();
    ready_en = 1'b0;
    step();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
